// File: rtl/ccff_chain_loader_pkg.sv
// ccff_chain_loader_pkg
// Shared types for the configuration-chain loader.
//   state_t   : loader FSM states (IDLE, SHIFT, DRAIN, DONE)
//   cnt_width : ceil(log2(n)), never less than 1, used for counter widths
package ccff_chain_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// ccff_chain_loader_if
// Bitstream input stream and readback output stream of the loader.
//   cfg_data/cfg_valid/cfg_ready : bitstream words into the loader
//   rb_data/rb_valid/rb_ready    : readback words out of the loader
// Handshake rule for both streams: a word transfers on a rising clock edge
// where valid && ready are both 1. Once valid is raised the producer holds
// valid and data stable until that transfer; ready may change freely and
// never depends combinationally on valid.
// master = bitstream source / readback sink, slave = the loader.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 32
) ();

  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;
  logic              rb_ready;

  modport master (
    output cfg_data, cfg_valid, rb_ready,
    input  cfg_ready, rb_data, rb_valid
  );

  modport slave (
    input  cfg_data, cfg_valid, rb_ready,
    output cfg_ready, rb_data, rb_valid
  );

endinterface

// File: rtl/ccff_rb_packer.sv
// ccff_rb_packer
// Collects serial bits into WORD_W-bit readback words, bit 0 first.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : start of a new load; empties collector, drops rb_valid
//   shift     : bit_in is captured this cycle
//   bit_in    : serial bit (pre-edge chain tail)
//   last      : this shift is the final bit of the load (flush partial word)
//   rb_data   : packed readback word, unused high bits 0
//   rb_valid  : rb_data valid, held until rb_ready
//   rb_ready  : consumer ready
module ccff_rb_packer
  import ccff_chain_loader_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift,
  input  logic              bit_in,
  input  logic              last,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              rb_ready
);

  localparam int IDX_W = cnt_width(WORD_W);
  localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0] coll_q, coll_d;
  logic [IDX_W-1:0]  pos_q, pos_d;
  logic [WORD_W-1:0] rb_data_q, rb_data_d;
  logic              rb_valid_q, rb_valid_d;

  always_comb begin
    coll_d     = coll_q;
    pos_d      = pos_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = rb_valid_q;
    if (rb_valid_q && rb_ready) rb_valid_d = 1'b0;
    // The loader never shifts while a word is stuck unaccepted, so a flush
    // here either finds rb_valid low or coincides with its handshake.
    if (shift) begin
      coll_d[pos_q] = bit_in;
      if (pos_q == LAST_POS || last) begin
        rb_data_d  = coll_d;
        rb_valid_d = 1'b1;
        coll_d     = '0;
        pos_d      = '0;
      end else begin
        pos_d = pos_q + 1'b1;
      end
    end
    if (clear) begin
      coll_d     = '0;
      pos_d      = '0;
      rb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coll_q     <= '0;
      pos_q      <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      coll_q     <= coll_d;
      pos_q      <= pos_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
// Writer end of a tile configuration scan chain. Serialises exactly
// CHAIN_LEN bits from the bitstream stream into ccff_head and returns the
// bits leaving ccff_tail as packed readback words.
//   prog_clk, prog_reset : clock, synchronous active-high reset
//   start                : single-cycle pulse, begins a load (IDLE/DONE only)
//   bus                  : cfg (bitstream in) and rb (readback out) streams
//   ccff_head            : serial bit into the chain (combinational)
//   ccff_shift_en        : chain shifts on this edge (combinational)
//   ccff_tail            : bit leaving the chain
//   busy, done           : SHIFT/DRAIN, DONE
//   bit_count            : bits shifted so far in this load
//   state_dbg            : FSM state
module ccff_chain_loader
  import ccff_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 32,
  localparam int CNT_W    = cnt_width(CHAIN_LEN + 1)
) (
  input  logic               prog_clk,
  input  logic               prog_reset,
  input  logic               start,
  ccff_chain_loader_if.slave bus,
  output logic               ccff_head,
  output logic               ccff_shift_en,
  input  logic               ccff_tail,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   bit_count,
  output state_t             state_dbg
);

  localparam int IDX_W = cnt_width(WORD_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] FINAL_BC = CNT_W'(CHAIN_LEN - 1);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              buf_valid_q, buf_valid_d;
  logic [CNT_W-1:0]  bit_count_q, bit_count_d;

  logic        shift, last_bit, final_bit, start_load;
  logic        cfg_ready, cfg_fire, rb_fire, rb_valid;
  logic [31:0] remaining, pending;

  // A pending readback word that the consumer refuses freezes the chain so
  // the collector is never overwritten. Reset stops shifting immediately.
  assign shift     = (state_q == ST_SHIFT) && buf_valid_q &&
                     !(rb_valid && !bus.rb_ready) && !prog_reset;
  assign last_bit  = shift && (idx_q == LAST_IDX);
  assign final_bit = shift && (bit_count_q == FINAL_BC);

  // Bits already shifted plus bits still queued in the buffer; a new word is
  // only taken while the chain still needs more than that.
  assign remaining = buf_valid_q ? (32'(WORD_W) - 32'(idx_q)) : 32'd0;
  assign pending   = 32'(bit_count_q) + remaining;
  assign cfg_ready = (state_q == ST_SHIFT) && (!buf_valid_q || last_bit) &&
                     (pending < 32'(CHAIN_LEN));
  assign cfg_fire  = bus.cfg_valid && cfg_ready;
  assign rb_fire   = rb_valid && bus.rb_ready;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    idx_d       = idx_q;
    buf_valid_d = buf_valid_q;
    bit_count_d = bit_count_q;
    start_load  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_SHIFT;
          buf_d       = '0;
          idx_d       = '0;
          buf_valid_d = 1'b0;
          bit_count_d = '0;
          start_load  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (shift) begin
          bit_count_d = bit_count_q + 1'b1;
          idx_d       = idx_q + 1'b1;
          if (last_bit) buf_valid_d = 1'b0;
        end
        if (cfg_fire) begin
          buf_d       = bus.cfg_data;
          idx_d       = '0;
          buf_valid_d = 1'b1;
        end
        // Leftover bits of the last word are dropped here.
        if (final_bit) begin
          state_d     = ST_DRAIN;
          buf_valid_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        // Only the final (possibly partial) word can be outstanding here.
        if (rb_fire) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q     <= ST_IDLE;
      buf_q       <= '0;
      idx_q       <= '0;
      buf_valid_q <= 1'b0;
      bit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      idx_q       <= idx_d;
      buf_valid_q <= buf_valid_d;
      bit_count_q <= bit_count_d;
    end
  end

  ccff_rb_packer #(
    .WORD_W (WORD_W)
  ) u_packer (
    .clk      (prog_clk),
    .rst      (prog_reset),
    .clear    (start_load),
    .shift    (shift),
    .bit_in   (ccff_tail),
    .last     (final_bit),
    .rb_data  (bus.rb_data),
    .rb_valid (rb_valid),
    .rb_ready (bus.rb_ready)
  );

  assign bus.rb_valid  = rb_valid;
  assign bus.cfg_ready = cfg_ready;
  assign ccff_shift_en = shift;
  assign ccff_head     = shift ? buf_q[idx_q] : 1'b0;
  assign busy          = (state_q == ST_SHIFT) || (state_q == ST_DRAIN);
  assign done          = (state_q == ST_DONE);
  assign bit_count     = bit_count_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader
// Directed bench for ccff_chain_loader with CHAIN_LEN=10, WORD_W=4 and a
// behavioural 10-flop chain (head enters chain[0], tail is chain[9]).
module tb_ccff_chain_loader;
  import ccff_chain_loader_pkg::*;

  localparam int CL = 10;
  localparam int WW = 4;
  localparam int CW = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          prog_clk = 1'b0;
  logic          prog_reset;
  logic          start;
  logic          ccff_head, ccff_shift_en, ccff_tail;
  logic          busy, done;
  logic [CW-1:0] bit_count;
  state_t        state_dbg;

  ccff_chain_loader_if #(.WORD_W(WW)) bus ();

  ccff_chain_loader #(
    .CHAIN_LEN (CL),
    .WORD_W    (WW)
  ) dut (
    .prog_clk      (prog_clk),
    .prog_reset    (prog_reset),
    .start         (start),
    .bus           (bus),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .bit_count     (bit_count),
    .state_dbg     (state_dbg)
  );

  always #5 prog_clk = ~prog_clk;

  // ---------------- chain model ----------------
  logic [CL-1:0] chain;
  logic          preload_en;
  logic [CL-1:0] preload_val;

  always @(posedge prog_clk) begin
    if (preload_en) chain <= preload_val;
    else if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head};
  end
  assign ccff_tail = chain[CL-1];

  // ---------------- bookkeeping ----------------
  int         checks = 0;
  int         errors = 0;
  logic [3:0] rb_got[$];
  logic [3:0] exp_q[$];
  logic [3:0] got;
  logic [13:0] obs;
  int         shift_cnt, first_sh, last_sh, done_n, words_used;
  int         stall_shifts, bc_at_hold, shift_at_release;
  bit         aborted;

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [CL-1:0] v);
    preload_val = v;
    preload_en  = 1'b1;
    @(negedge prog_clk);
    preload_en  = 1'b0;
  endtask

  // Pulses start, feeds three words and collects readback until done.
  // sparse: each word waits 3 idle cycles before valid is raised.
  // rb_hold: rb_ready starts low and is raised rb_hold cycles after the
  //          first readback word appears.
  // abort_bc: return as soon as bit_count equals this value (-1 = never).
  // pulse_start: extra start pulses at bit_count==3 in SHIFT and in DRAIN.
  task automatic do_load(input logic [3:0] w0, input logic [3:0] w1, input logic [3:0] w2,
                         input bit sparse, input int rb_hold, input int abort_bc,
                         input bit pulse_start);
    logic [3:0] wq[3];
    int idle, hold_n;
    bit released, rel_seen;
    wq = '{w0, w1, w2};
    rb_got.delete();
    shift_cnt = 0; first_sh = -1; last_sh = -1; done_n = -1; words_used = 0;
    stall_shifts = 0; bc_at_hold = -1; shift_at_release = -1; aborted = 1'b0;
    idle = 0; hold_n = 0; released = (rb_hold == 0); rel_seen = 1'b0;
    bus.rb_ready  = released;
    bus.cfg_valid = 1'b0;
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (done) begin done_n = n; break; end
      if (abort_bc >= 0 && int'(bit_count) == abort_bc) begin aborted = 1'b1; break; end
      start = pulse_start && ((state_dbg == ST_SHIFT && bit_count == 4'd3) ||
                              state_dbg == ST_DRAIN);
      if (words_used < 3 && (!sparse || idle >= 3)) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = wq[words_used];
      end else begin
        bus.cfg_valid = 1'b0;
      end
      if (!released && bus.rb_valid) begin
        if (hold_n < rb_hold) hold_n++;
        else begin bus.rb_ready = 1'b1; released = 1'b1; end
      end
      #1;
      if (!released && bus.rb_valid) begin
        if (ccff_shift_en) stall_shifts++;
        bc_at_hold = int'(bit_count);
      end
      if (rb_hold > 0 && released && !rel_seen) begin
        rel_seen = 1'b1;
        shift_at_release = int'(ccff_shift_en);
      end
      if (ccff_shift_en) begin
        shift_cnt++;
        if (first_sh < 0) first_sh = n;
        last_sh = n;
      end
      if (bus.rb_valid && bus.rb_ready) rb_got.push_back(bus.rb_data);
      if (bus.cfg_valid && bus.cfg_ready) begin words_used++; idle = 0; end
      else if (!bus.cfg_valid) idle++;
      @(negedge prog_clk);
    end
    start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.rb_ready = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    prog_reset = 1'b1; start = 1'b0; preload_en = 1'b0; preload_val = '0;
    bus.cfg_valid = 1'b0; bus.cfg_data = '0; bus.rb_ready = 1'b0;
    repeat (3) @(negedge prog_clk);
    preload(10'h000);
    obs = {bus.cfg_ready, ccff_shift_en, ccff_head, bus.rb_valid, busy, done, bus.rb_data, bit_count};
    checks++; if (obs !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", obs); end
    checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", state_dbg, ST_IDLE); end
    prog_reset = 1'b0;
    @(negedge prog_clk);
    checks++; if (state_dbg !== ST_IDLE || ccff_shift_en !== 1'b0) begin
      errors++; $display("FAIL idle_hold got state %0d shift %b exp 0 0", state_dbg, ccff_shift_en); end
  endtask

  task automatic test_basic();
    do_load(4'hA, 4'h5, 4'h3, 1'b0, 0, -1, 1'b0);
    checks++; if (shift_cnt !== 10) begin errors++; $display("FAIL s1_shift_cnt got %0d exp 10", shift_cnt); end
    checks++; if (last_sh - first_sh + 1 !== 10) begin
      errors++; $display("FAIL s1_contiguous got span %0d exp 10", last_sh - first_sh + 1); end
    checks++; if (first_sh !== 1) begin errors++; $display("FAIL s1_first_shift got %0d exp 1", first_sh); end
    checks++; if (chain !== 10'h16B) begin errors++; $display("FAIL s1_chain got %h exp 16b", chain); end
    checks++; if (done_n !== 12) begin errors++; $display("FAIL s1_done_cycle got %0d exp 12", done_n); end
    checks++; if (words_used !== 3) begin errors++; $display("FAIL s1_words got %0d exp 3", words_used); end
    checks++; if (bit_count !== 4'd10) begin errors++; $display("FAIL s1_bit_count got %0d exp 10", bit_count); end
    exp_q = '{4'h0, 4'h0, 4'h0};
    checks++; if (rb_got.size() != 3) begin errors++; $display("FAIL s1_rb_count got %0d exp 3", rb_got.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < rb_got.size()) ? rb_got[i] : 4'hx;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL s1_rb_word%0d got %h exp %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_readback();
    do_load(4'hF, 4'hF, 4'h3, 1'b0, 0, -1, 1'b0);
    checks++; if (chain !== 10'h3FF) begin errors++; $display("FAIL s2_chain got %h exp 3ff", chain); end
    checks++; if (done_n !== 12) begin errors++; $display("FAIL s2_done_cycle got %0d exp 12", done_n); end
    exp_q = '{4'hA, 4'h5, 4'h3};
    checks++; if (rb_got.size() != 3) begin errors++; $display("FAIL s2_rb_count got %0d exp 3", rb_got.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < rb_got.size()) ? rb_got[i] : 4'hx;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL s2_rb_word%0d got %h exp %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_rb_stall();
    do_load(4'hA, 4'h5, 4'h3, 1'b0, 4, -1, 1'b0);
    checks++; if (stall_shifts !== 0) begin errors++; $display("FAIL s3_stall_shifts got %0d exp 0", stall_shifts); end
    checks++; if (bc_at_hold !== 4) begin errors++; $display("FAIL s3_hold_bit_count got %0d exp 4", bc_at_hold); end
    checks++; if (shift_at_release !== 1) begin
      errors++; $display("FAIL s3_shift_at_release got %0d exp 1", shift_at_release); end
    checks++; if (done_n !== 16) begin errors++; $display("FAIL s3_done_cycle got %0d exp 16", done_n); end
    checks++; if (chain !== 10'h16B) begin errors++; $display("FAIL s3_chain got %h exp 16b", chain); end
    exp_q = '{4'hF, 4'hF, 4'h3};
    checks++; if (rb_got.size() != 3) begin errors++; $display("FAIL s3_rb_count got %0d exp 3", rb_got.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < rb_got.size()) ? rb_got[i] : 4'hx;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL s3_rb_word%0d got %h exp %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_sparse_cfg();
    do_load(4'hA, 4'h5, 4'h3, 1'b1, 0, -1, 1'b0);
    checks++; if (shift_cnt !== 10) begin errors++; $display("FAIL s4_shift_cnt got %0d exp 10", shift_cnt); end
    checks++; if (first_sh !== 4) begin errors++; $display("FAIL s4_first_shift got %0d exp 4", first_sh); end
    checks++; if (done_n !== 15) begin errors++; $display("FAIL s4_done_cycle got %0d exp 15", done_n); end
    checks++; if (chain !== 10'h16B) begin errors++; $display("FAIL s4_chain got %h exp 16b", chain); end
    exp_q = '{4'hA, 4'h5, 4'h3};
    checks++; if (rb_got.size() != 3) begin errors++; $display("FAIL s4_rb_count got %0d exp 3", rb_got.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < rb_got.size()) ? rb_got[i] : 4'hx;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL s4_rb_word%0d got %h exp %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    do_load(4'hF, 4'hF, 4'h3, 1'b0, 0, 6, 1'b0);
    checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL s5_reached_bc6 got %b exp 1", aborted); end
    prog_reset = 1'b1;
    #1;
    checks++; if (ccff_shift_en !== 1'b0) begin errors++; $display("FAIL s5_shift_in_reset got %b exp 0", ccff_shift_en); end
    @(negedge prog_clk);
    obs = {bus.cfg_ready, ccff_shift_en, ccff_head, bus.rb_valid, busy, done, bus.rb_data, bit_count};
    checks++; if (obs !== '0) begin errors++; $display("FAIL s5_outputs got %h exp 0", obs); end
    checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL s5_state got %0d exp %0d", state_dbg, ST_IDLE); end
    prog_reset = 1'b0;
    preload(10'h000);
    do_load(4'hA, 4'h5, 4'h3, 1'b0, 0, -1, 1'b0);
    checks++; if (done_n !== 12) begin errors++; $display("FAIL s5_reload_done got %0d exp 12", done_n); end
    checks++; if (chain !== 10'h16B) begin errors++; $display("FAIL s5_chain got %h exp 16b", chain); end
    exp_q = '{4'h0, 4'h0, 4'h0};
    checks++; if (rb_got.size() != 3) begin errors++; $display("FAIL s5_rb_count got %0d exp 3", rb_got.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < rb_got.size()) ? rb_got[i] : 4'hx;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL s5_rb_word%0d got %h exp %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_start_ignored();
    do_load(4'hF, 4'hF, 4'h3, 1'b0, 0, -1, 1'b1);
    checks++; if (shift_cnt !== 10) begin errors++; $display("FAIL s6_shift_cnt got %0d exp 10", shift_cnt); end
    checks++; if (done_n !== 12) begin errors++; $display("FAIL s6_done_cycle got %0d exp 12", done_n); end
    checks++; if (chain !== 10'h3FF) begin errors++; $display("FAIL s6_chain got %h exp 3ff", chain); end
    exp_q = '{4'hA, 4'h5, 4'h3};
    checks++; if (rb_got.size() != 3) begin errors++; $display("FAIL s6_rb_count got %0d exp 3", rb_got.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < rb_got.size()) ? rb_got[i] : 4'hx;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL s6_rb_word%0d got %h exp %h", i, got, exp_q[i]); end
    end
    checks++; if (state_dbg !== ST_DONE || done !== 1'b1 || bit_count !== 4'd10) begin
      errors++; $display("FAIL s6_done_hold got state %0d done %b bc %0d exp 3 1 10", state_dbg, done, bit_count); end
    // start in DONE begins a fresh load
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    checks++; if (bit_count !== 4'd0 || done !== 1'b0 || busy !== 1'b1 || state_dbg !== ST_SHIFT) begin
      errors++; $display("FAIL s6_restart got bc %0d done %b busy %b state %0d exp 0 0 1 1",
                         bit_count, done, busy, state_dbg); end
    // The start pulse inside do_load now lands in SHIFT and is ignored.
    do_load(4'hF, 4'hF, 4'h3, 1'b0, 0, -1, 1'b0);
    checks++; if (shift_cnt !== 10) begin errors++; $display("FAIL s6b_shift_cnt got %0d exp 10", shift_cnt); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL s6b_done got %b exp 1", done); end
    exp_q = '{4'hF, 4'hF, 4'h3};
    checks++; if (rb_got.size() != 3) begin errors++; $display("FAIL s6b_rb_count got %0d exp 3", rb_got.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < rb_got.size()) ? rb_got[i] : 4'hx;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL s6b_rb_word%0d got %h exp %h", i, got, exp_q[i]); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_readback();
    test_rb_stall();
    test_sparse_cfg();
    test_reset_mid();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Writer end of the configuration-chain protocol: drives ccff_head and a shift enable into a tile's ccff_head→ccff_tail scan chain.
- Accepts bitstream words on a valid/ready stream and serialises exactly CHAIN_LEN bits.
- Captures the bits leaving ccff_tail and returns them as packed readback words.
- Sits at fabric top, between the bitstream source and the first tile's ccff_head; the last tile's ccff_tail returns to it.

Parameters:
CHAIN_LEN, 1024, total configuration bits in the chain (≥1)
WORD_W, 32, bitstream and readback word width (≥2)
CNT_W, $clog2(CHAIN_LEN+1), bit counter width (derived, not overridden)

Ports:
prog_clk  in  1  programming clock; all state on rising edge
prog_reset  in  1  synchronous active-high reset
start  in  1  single-cycle pulse, begins a load
cfg_data  in  WORD_W  bitstream word; bit 0 shifted first
cfg_valid  in  1  cfg_data valid
cfg_ready  out  1  loader accepts cfg_data this cycle
ccff_head  out  1  serial bit into chain (combinational)
ccff_shift_en  out  1  chain clock enable; chain shifts on this edge (combinational)
ccff_tail  in  1  bit leaving the chain
rb_data  out  WORD_W  readback word; bit 0 = first bit out of ccff_tail
rb_valid  out  1  rb_data valid, held until rb_ready
rb_ready  in  1  readback consumer ready
busy  out  1  state is SHIFT or DRAIN
done  out  1  level, high in DONE
bit_count  out  CNT_W  bits shifted so far in the current load

Behaviour:
- Reset: state=IDLE. Word buffer, collector, bit_count and rb_data are 0. cfg_ready, ccff_shift_en, ccff_head, rb_valid, busy and done are 0.
- Reset mid-load aborts at once. No further shift occurs. Chain contents are undefined.
- States: IDLE, SHIFT, DRAIN, DONE.
  - IDLE/DONE + start → SHIFT. bit_count, word buffer and collector clear; rb_valid drops.
  - start is ignored in SHIFT and DRAIN.
- Word buffer: holds one word plus a bit index (0..WORD_W-1) and buf_valid.
  - cfg_ready = (state==SHIFT) && (!buf_valid || last-bit shift this cycle) && bit_count+remaining < CHAIN_LEN.
  - With this rule, 1 bit/cycle is sustained across word boundaries.
- Shift cycle: state==SHIFT && buf_valid && !(rb_valid && !rb_ready).
  - ccff_shift_en=1 and ccff_head=buf[idx], both combinational.
  - At that edge: the chain captures ccff_head; ccff_tail (pre-edge value) enters the collector at position (bit_count mod WORD_W); bit_count++; idx++.
  - Otherwise ccff_shift_en=0 and ccff_head=0.
- Collector: when a word fills (WORD_W bits) or bit_count reaches CHAIN_LEN, load rb_data and set rb_valid at the same edge.
  - Unused high bits of a final partial word are 0.
  - rb_valid clears on the rb_valid&&rb_ready handshake.
  - A shift may coincide with that handshake. The new bit goes to collector position 0.
- Completion: the edge where bit_count becomes CHAIN_LEN → DRAIN.
  - Unshifted bits left in the buffer are discarded; buf_valid clears.
  - cfg_ready=0 from then on.
- DRAIN → DONE on the final readback handshake. This can be the first cycle in DRAIN if rb_ready=1.
- Words consumed per load = ceil(CHAIN_LEN/WORD_W). Readback words per load = the same.
- Latency: first shift occurs 1 cycle after the first cfg handshake. Minimum load time with cfg_valid=rb_ready=1 is CHAIN_LEN cycles plus 2.
- bit_count saturates at CHAIN_LEN; it holds in DRAIN/DONE until the next start.

Decomposition:
- Package ccff_chain_loader_pkg holds the state enum (IDLE, SHIFT, DRAIN, DONE) and the clog2-based width helper.
- One natural sub-module: ccff_rb_packer (serial→WORD_W collector with valid/ready output and final-partial flush).

Test Plan:
- Common setup: CHAIN_LEN=10, WORD_W=4, behavioural 10-FF chain model clocked when ccff_shift_en=1.
1. Chain preloaded 10'h000, start, words 4'hA,4'h5,4'h3 (cfg_valid, rb_ready=1).
   - Exactly 10 shift cycles, contiguous.
   - Chain holds bits in order 0,1,0,1,1,0,1,0,1,1.
   - rb words: 0,0,0 (last partial 2 bits).
   - done=1 at cycle 12 after start. Upper 2 bits of word 4'h3 are discarded.
2. Repeat load with 4'hF,4'hF,4'h3.
   - Readback words equal 4'hA,4'h5,4'h3 & 4'h3, i.e. the previous contents in order.
3. rb_ready held 0 after the first readback word.
   - ccff_shift_en stays 0 and bit_count holds at 4.
   - rb_ready=1 → the next shift occurs in the same cycle as the handshake.
4. cfg_valid toggled 1 cycle on/3 off.
   - Shifts occur only when buf_valid=1; the final chain contents match scenario 1.
5. prog_reset asserted at bit_count=6.
   - Next cycle: all outputs 0, state IDLE, no shift.
   - A subsequent start and full load completes correctly.
6. start pulses during SHIFT and DRAIN are ignored.
   - start in DONE begins a new load with bit_count=0 and done=0.
